// File: rtl/pc_sequencer_if.sv
// Sequencer <-> core bundle: instruction fetch, branch LUT, flag and run/done status.
// master = sequencer side (drives pc/status), slave = ROM/decoder/ALU/bench side.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic              start;
  logic [5:0]        instr_op;
  logic [2:0]        instr_arg;
  logic              alu_overflow;
  logic              flag_we;
  logic [PC_W-1:0]   lut_target;
  logic [PC_W-1:0]   pc;
  logic [2:0]        lut_idx;
  logic              flag;
  logic              running;
  logic              done;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    input  start, instr_op, instr_arg, alu_overflow, flag_we, lut_target,
    output pc, lut_idx, flag, running, done, cycle_count
  );

  modport slave (
    output start, instr_op, instr_arg, alu_overflow, flag_we, lut_target,
    input  pc, lut_idx, flag, running, done, cycle_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter / branch / halt sequencer; one instruction retires per RUN cycle.
// No backpressure: pc is combinational to ROM, branch and flag results land on the next edge.
module pc_sequencer #(
  parameter int          PC_W       = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int          CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t            state;
  logic [PC_W-1:0]   pc_q;
  logic              flag_q;
  logic              running_q;
  logic              done_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [2:0] op;
  logic [2:0] func;
  logic       is_bno;
  logic       is_bof;
  logic       is_halt;
  logic       br_taken;

  assign op   = bus.instr_op[5:3];
  assign func = bus.instr_op[2:0];

  assign is_bno  = (op == 3'b111) && (func == 3'b000);
  assign is_bof  = (op == 3'b111) && (func == 3'b001);
  assign is_halt = (op == 3'b110) && (func == 3'b111);

  // Branch decision uses the flag as it stood before this edge, even if flag_we updates it now.
  assign br_taken = (is_bno && !flag_q) || (is_bof && flag_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc_q      <= '0;
      flag_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (bus.start) begin
            state     <= RUN;
            pc_q      <= START_PC;
            flag_q    <= 1'b0;
            cnt_q     <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        RUN: begin
          if (bus.flag_we) begin
            flag_q <= bus.alu_overflow;
          end
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
          if (is_halt) begin
            state     <= HALTED;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (br_taken) begin
            pc_q <= bus.lut_target;
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.lut_idx     = bus.instr_arg;
  assign bus.flag        = flag_q;
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, async-reset sequence, randomized run
// against a behavioural model, and a wrap/saturation run on a second instance.
module tb_pc_sequencer;

  localparam logic [5:0] ADD  = 6'b010000;
  localparam logic [5:0] HALT = 6'b110111;
  localparam logic [5:0] BNO  = 6'b111000;
  localparam logic [5:0] BOF  = 6'b111001;

  logic clk;
  logic rst_n;
  logic rst2_n;

  int checks = 0;
  int errors = 0;

  pc_sequencer_if #(.PC_W(10), .CNT_W(16)) bus1 ();
  pc_sequencer_if #(.PC_W(10), .CNT_W(16)) bus2 ();

  pc_sequencer #(.PC_W(10), .START_ADDR(0), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  pc_sequencer #(.PC_W(10), .START_ADDR(32'h3FE), .CNT_W(16)) u_dut_wrap (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [5:0]  op;
    logic [2:0]  arg;
    logic        ov;
    logic        we;
    logic [9:0]  tgt;
    logic [9:0]  e_pc;
    logic        e_flag;
    logic        e_run;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  // Behavioural reference: what the core has architecturally done so far.
  bit m_run, m_done, m_flag;
  int m_pc, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic start, input logic [5:0] op, input logic [2:0] arg,
                              input logic ov, input logic we, input logic [9:0] tgt,
                              input logic [9:0] e_pc, input logic e_flag, input logic e_run,
                              input logic e_done, input logic [15:0] e_cnt);
    vec_t v;
    v.start = start; v.op = op; v.arg = arg; v.ov = ov; v.we = we; v.tgt = tgt;
    v.e_pc = e_pc; v.e_flag = e_flag; v.e_run = e_run; v.e_done = e_done; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endfunction

  task automatic drive1(input logic start, input logic [5:0] op, input logic [2:0] arg,
                        input logic ov, input logic we, input logic [9:0] tgt);
    bus1.start = start; bus1.instr_op = op; bus1.instr_arg = arg;
    bus1.alu_overflow = ov; bus1.flag_we = we; bus1.lut_target = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all1(input string tag, input logic [9:0] pc, input logic flag,
                            input logic run, input logic done, input logic [15:0] cnt);
    chk({tag, ".pc"}, 32'(bus1.pc), 32'(pc));
    chk({tag, ".flag"}, 32'(bus1.flag), 32'(flag));
    chk({tag, ".running"}, 32'(bus1.running), 32'(run));
    chk({tag, ".done"}, 32'(bus1.done), 32'(done));
    chk({tag, ".cycle_count"}, 32'(bus1.cycle_count), 32'(cnt));
  endtask

  function automatic void model_reset();
    m_run = 0; m_done = 0; m_flag = 0; m_pc = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input logic start, input logic [5:0] op, input logic ov,
                                     input logic we, input logic [9:0] tgt);
    bit taken;
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0; m_flag = 0;
      end
    end else begin
      taken = (op == BNO && !m_flag) || (op == BOF && m_flag);
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (we) m_flag = ov;
      if (op == HALT) begin
        m_run = 0; m_done = 1;
      end else if (taken) begin
        m_pc = int'(tgt);
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end
  endfunction

  initial begin
    logic [5:0] r_op;
    logic       r_start;

    rst_n  = 1'b0;
    rst2_n = 1'b0;
    drive1(0, ADD, 0, 0, 0, 0);
    bus2.start = 0; bus2.instr_op = ADD; bus2.instr_arg = 0;
    bus2.alu_overflow = 0; bus2.flag_we = 0; bus2.lut_target = 0;
    #3;
    check_all1("reset", 10'h0, 0, 0, 0, 16'h0);
    #10;
    rst_n = 1'b1;
    tick();

    // start, pc, flag, run, done, count expected after each edge
    add(1, ADD,       0, 0, 0, 10'h000, 10'h000, 0, 1, 0, 0);
    add(0, ADD,       1, 0, 0, 10'h000, 10'h001, 0, 1, 0, 1);
    add(0, ADD,       2, 0, 0, 10'h000, 10'h002, 0, 1, 0, 2);
    add(0, ADD,       3, 0, 0, 10'h000, 10'h003, 0, 1, 0, 3);
    add(0, ADD,       4, 1, 1, 10'h000, 10'h004, 1, 1, 0, 4);
    add(0, HALT,      7, 0, 0, 10'h000, 10'h004, 1, 0, 1, 5);
    add(0, ADD,       0, 0, 1, 10'h000, 10'h004, 1, 0, 1, 5);
    add(1, ADD,       0, 0, 0, 10'h000, 10'h000, 0, 1, 0, 0);
    add(0, ADD,       0, 0, 0, 10'h000, 10'h001, 0, 1, 0, 1);
    add(0, ADD,       0, 0, 0, 10'h000, 10'h002, 0, 1, 0, 2);
    add(0, ADD,       0, 1, 1, 10'h000, 10'h003, 1, 1, 0, 3);
    add(0, BOF,       3, 0, 0, 10'h040, 10'h040, 1, 1, 0, 4);
    add(0, HALT,      0, 0, 0, 10'h000, 10'h040, 1, 0, 1, 5);
    add(1, ADD,       0, 0, 0, 10'h000, 10'h000, 0, 1, 0, 0);
    add(0, ADD,       0, 0, 0, 10'h000, 10'h001, 0, 1, 0, 1);
    add(0, ADD,       0, 0, 0, 10'h000, 10'h002, 0, 1, 0, 2);
    add(0, ADD,       0, 0, 1, 10'h000, 10'h003, 0, 1, 0, 3);
    add(0, BOF,       3, 0, 0, 10'h040, 10'h004, 0, 1, 0, 4);
    add(0, BNO,       5, 1, 1, 10'h123, 10'h123, 1, 1, 0, 5);
    add(0, BNO,       1, 0, 0, 10'h200, 10'h124, 1, 1, 0, 6);
    add(0, BOF,       2, 0, 1, 10'h010, 10'h010, 0, 1, 0, 7);
    add(0, 6'b111010, 6, 0, 0, 10'h2AA, 10'h011, 0, 1, 0, 8);
    add(0, 6'b000101, 4, 0, 0, 10'h155, 10'h012, 0, 1, 0, 9);
    add(1, ADD,       0, 0, 0, 10'h000, 10'h013, 0, 1, 0, 10);
    add(0, HALT,      0, 1, 1, 10'h000, 10'h013, 1, 0, 1, 11);
    add(0, ADD,       0, 0, 1, 10'h000, 10'h013, 1, 0, 1, 11);

    foreach (tbl[i]) begin
      drive1(tbl[i].start, tbl[i].op, tbl[i].arg, tbl[i].ov, tbl[i].we, tbl[i].tgt);
      tick();
      check_all1($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_flag, tbl[i].e_run,
                 tbl[i].e_done, tbl[i].e_cnt);
      chk($sformatf("vec%0d.lut_idx", i), 32'(bus1.lut_idx), 32'(tbl[i].arg));
    end

    // Async reset mid-RUN at pc=5, visible without a clock edge.
    drive1(1, ADD, 0, 0, 0, 0);
    tick();
    drive1(0, ADD, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) tick();
    check_all1("prerst", 10'h005, 1, 1, 0, 16'd5);
    rst_n = 1'b0;
    #1;
    check_all1("midrst", 10'h000, 0, 0, 0, 16'd0);
    #2;
    rst_n = 1'b1;
    drive1(1, ADD, 0, 0, 0, 0);
    tick();
    check_all1("rststart", 10'h000, 0, 1, 0, 16'd0);
    drive1(0, ADD, 0, 0, 0, 0);

    // Randomized run against the model.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0:       r_op = HALT;
        1, 2:    r_op = BNO;
        3, 4:    r_op = BOF;
        5:       r_op = {3'b111, 3'($urandom_range(2, 7))};
        default: r_op = 6'($urandom);
      endcase
      r_start = ($urandom_range(0, 3) == 0);
      drive1(r_start, r_op, 3'($urandom), 1'($urandom), 1'($urandom),
             10'($urandom_range(0, 1023)));
      @(posedge clk);
      model_step(bus1.start, bus1.instr_op, bus1.alu_overflow, bus1.flag_we, bus1.lut_target);
      #1;
      check_all1($sformatf("rnd%0d", n), 10'(m_pc), m_flag, m_run, m_done, 16'(m_cnt));
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all1($sformatf("rndrst%0d", n), 10'(m_pc), m_flag, m_run, m_done, 16'(m_cnt));
        rst_n = 1'b1;
      end
    end
    drive1(0, ADD, 0, 0, 0, 0);

    // Wrap and saturation on the START_ADDR=0x3FE instance.
    rst2_n = 1'b1;
    bus2.start = 1'b1;
    tick();
    chk("wrap.pc0", 32'(bus2.pc), 32'h3FE);
    chk("wrap.running", 32'(bus2.running), 32'h1);
    bus2.start = 1'b0;
    for (int n = 1; n <= 65540; n++) begin
      tick();
      if (bus2.pc !== 10'((32'h3FE + n) % 1024) ||
          bus2.cycle_count !== 16'((n < 65535) ? n : 65535)) begin
        chk($sformatf("wrap%0d.pc", n), 32'(bus2.pc), (32'h3FE + n) % 1024);
        chk($sformatf("wrap%0d.cnt", n), 32'(bus2.cycle_count),
            (n < 65535) ? 32'(n) : 32'hFFFF);
      end else if (n <= 2 || n >= 65534) begin
        chk($sformatf("wrap%0d.pc", n), 32'(bus2.pc), (32'h3FE + n) % 1024);
        chk($sformatf("wrap%0d.cnt", n), 32'(bus2.cycle_count),
            (n < 65535) ? 32'(n) : 32'hFFFF);
      end
    end
    chk("sat.cnt", 32'(bus2.cycle_count), 32'hFFFF);
    chk("sat.done", 32'(bus2.done), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
